// File: rtl/ahb_uart_rx.sv
// AHB-Lite zero-wait-state slave wrapping an 8N1 UART receiver and a small receive FIFO.
// Map: 0x0 DATA (read pops head), 0x4 STATUS, 0x8 CLEAR (write-1-to-clear error flags).
module ahb_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  input  logic        UART_RX
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_meta_q, rx_s_q;
  logic            push, frame_set;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovr_q, ovr_d, ferr_q, ferr_d;
  logic            full, empty, pop, push_ok, ovr_set, clr_wr;

  logic            dp_valid_q, dp_write_q;
  logic [1:0]      dp_addr_q;

  logic            unused_ok;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:4], HWDATA[1:0]};

  assign HREADY = 1'b1;
  assign HRESP  = 1'b0;

  // Receive FSM: start bit checked at mid-bit, data and stop sampled a full bit later each.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TW'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d         = '0;
          shift_d[idx_q]  = rx_s_q;
          idx_d           = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        timer_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO and flag bookkeeping; a pop in the same cycle frees room for a push into a full FIFO.
  always_comb begin
    full    = (count_q == FULL_CNT);
    empty   = (count_q == '0);
    pop     = dp_valid_q && !dp_write_q && (dp_addr_q == 2'd0) && !empty;
    push_ok = push && (!full || pop);
    ovr_set = push && full && !pop;
    clr_wr  = dp_valid_q && dp_write_q && (dp_addr_q == 2'd2);
    ovr_d   = ovr_set   || (ovr_q  && !(clr_wr && HWDATA[2]));
    ferr_d  = frame_set || (ferr_q && !(clr_wr && HWDATA[3]));
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    if (dp_valid_q && !dp_write_q) begin
      case (dp_addr_q)
        2'd0:    if (!empty) HRDATA = {24'b0, mem_q[rd_ptr_q]};
        2'd1:    HRDATA = {19'b0, 5'(count_q), 4'b0, ferr_q, ovr_q, full, !empty};
        default: HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
    end else begin
      rx_meta_q  <= UART_RX;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
      dp_valid_q <= HSEL && HTRANS[1];
      dp_write_q <= HWRITE;
      dp_addr_q  <= HADDR[3:2];
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end
endmodule

// File: tb/tb_ahb_uart_rx.sv
// Scoreboard bench for ahb_uart_rx: stimulus queues expected read data, a negedge monitor checks it.
module tb_ahb_uart_rx;
  localparam int CPB = 8;

  logic        HCLK    = 1'b0;
  logic        HRESET  = 1'b1;
  logic [31:0] HADDR   = '0;
  logic        HSEL    = 1'b0;
  logic [1:0]  HTRANS  = 2'b00;
  logic        HWRITE  = 1'b0;
  logic [31:0] HWDATA  = '0;
  logic [31:0] HRDATA;
  logic        HREADY, HRESP;
  logic        UART_RX = 1'b1;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        tb_dp_rd   = 1'b0;
  logic        finish_req = 1'b0;
  logic        finish_ack = 1'b0;

  ahb_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HSEL(HSEL), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .UART_RX(UART_RX)
  );

  always #5 HCLK = ~HCLK;

  // Bench-side view of which cycles are read data phases.
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) tb_dp_rd <= 1'b0;
    else        tb_dp_rd <= HSEL & HTRANS[1] & ~HWRITE;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                       input bit verbose);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else if (verbose) begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  always @(negedge HCLK) begin
    if (tb_dp_rd) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read data phase with 0 queued, expected >=1");
      end else begin
        check(name_q.pop_front(), HRDATA, exp_q.pop_front(), 1'b1);
      end
    end else begin
      check("idle_hrdata", HRDATA, 32'h0, 1'b0);
    end
    check("hready_hresp", {30'b0, HREADY, HRESP}, 32'h2, 1'b0);
    if (finish_req && !finish_ack) begin
      check("sb_drained", 32'(exp_q.size()), 32'h0, 1'b1);
      finish_ack = 1'b1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_read(input logic [3:0] addr, input logic [31:0] exp, input string name);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h0, addr};
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h0, addr};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
    HWDATA = '0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    UART_RX = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      UART_RX = d[i];
      wait_cycles(CPB);
    end
    UART_RX = stop;
    wait_cycles(CPB);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    wait_cycles(3);
    HRESET = 1'b0;
    wait_cycles(1);
    ahb_read(4'h4, 32'h0, "reset_status");
    ahb_read(4'h0, 32'h0, "reset_data_empty");
    ahb_read(4'h8, 32'h0, "read_clear_zero");
    ahb_read(4'hC, 32'h0, "read_offc_zero");
    wait_cycles(2);

    send_frame(8'hA5, 1'b1);
    wait_cycles(2);
    ahb_read(4'h4, 32'h0000_0101, "a5_status");
    ahb_read(4'h0, 32'h0000_00A5, "a5_data");
    ahb_read(4'h4, 32'h0000_0000, "a5_status_after");
    wait_cycles(2);

    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      wait_cycles(2);
    end
    // count 4, full, overrun, not-empty
    ahb_read(4'h4, 32'h0000_0407, "ovr_status");
    for (int i = 1; i <= 4; i++) ahb_read(4'h0, 32'(i), "ovr_data");
    ahb_read(4'h0, 32'h0, "ovr_data_empty");
    ahb_read(4'h4, 32'h0000_0004, "ovr_status_drained");
    ahb_write(4'h8, 32'h4);
    ahb_read(4'h4, 32'h0, "ovr_cleared");
    wait_cycles(2);

    send_frame(8'h3C, 1'b0);
    UART_RX = 1'b0;
    wait_cycles(40);
    UART_RX = 1'b1;
    wait_cycles(4);
    send_frame(8'h11, 1'b1);
    wait_cycles(2);
    ahb_read(4'h4, 32'h0000_0109, "ferr_status");
    ahb_read(4'h0, 32'h0000_0011, "ferr_data");
    ahb_write(4'h8, 32'h8);
    ahb_read(4'h4, 32'h0, "ferr_cleared");
    wait_cycles(2);

    UART_RX = 1'b0;
    wait_cycles(2);
    UART_RX = 1'b1;
    wait_cycles(20);
    ahb_read(4'h4, 32'h0, "glitch_status");
    send_frame(8'h5A, 1'b1);
    wait_cycles(2);
    ahb_read(4'h4, 32'h0000_0101, "post_glitch_status");
    ahb_read(4'h0, 32'h0000_005A, "post_glitch_data");
    wait_cycles(2);

    // Stale byte in FIFO, then reset lands in bit 4 of a frame whose remaining bits are high.
    send_frame(8'h33, 1'b1);
    wait_cycles(2);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (43) @(posedge HCLK);
        #1 HRESET = 1'b1;
        @(posedge HCLK);
        #1 HRESET = 1'b0;
      end
    join
    wait_cycles(4);
    send_frame(8'h7E, 1'b1);
    wait_cycles(2);
    ahb_read(4'h4, 32'h0000_0101, "rst_status");
    ahb_read(4'h0, 32'h0000_007E, "rst_data");
    ahb_read(4'h4, 32'h0, "rst_status_after");
    wait_cycles(2);

    for (int i = 8'h21; i <= 8'h24; i++) begin
      send_frame(8'(i), 1'b1);
      wait_cycles(2);
    end
    ahb_read(4'h4, 32'h0000_0403, "full_status");
    // Data phase of this read ends on the same edge the stop bit is accepted.
    fork
      send_frame(8'h25, 1'b1);
      begin
        repeat (77) @(posedge HCLK);
        #1;
        ahb_read(4'h0, 32'h0000_0021, "race_pop");
      end
    join
    wait_cycles(2);
    ahb_read(4'h4, 32'h0000_0403, "race_status");
    for (int i = 8'h22; i <= 8'h25; i++) ahb_read(4'h0, 32'(i), "race_data");
    ahb_read(4'h4, 32'h0, "race_status_empty");
    wait_cycles(3);

    finish_req = 1'b1;
    wait_cycles(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
